exec_unit_pipelined: RTL and testbench

- Parametrised, registered execute stage for the RV32/RV64 core.
- Combines ALU, branch resolution, load/store address generation and an optional iterative M-extension multiply/divide unit.
- Sits between decode/operand-fetch and memory stage; valid/ready handshake on both sides.
- Multi-cycle M ops stall the upstream stage.

---
 rtl/exec_unit_pipelined.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_exec_unit_pipelined.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit_pipelined.sv
// -----------------------------------------------------------------------------
// exec_unit_pipelined
//
// Registered execute stage: ALU, branch resolution, load/store address and
// store-data generation, plus an optional iterative multiply/divide unit.
// Single-cycle ops are registered straight into the output stage; M ops walk
// an IDLE -> BUSY (XLEN iterations) -> DONE sequence and stall upstream.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready upstream handshake
//   in_type           one-hot class [0]R [1]I [2]S [3]B [4]U [5]J
//   in_alu_op         ALU operation code
//   in_muldiv         M-extension op (honoured for R-type only)
//   in_funct3         branch condition / store size / M-op select
//   in_op0, in_op1    rs1 / rs2 values
//   in_imm            sign-extended immediate
//   in_pc             instruction address
//   out_valid/out_ready downstream handshake
//   out_result        ALU / M / link result
//   out_branch        redirect taken
//   out_target        redirect address
//   out_mem_addr      op0 + imm effective address
//   out_store_data    size-masked store data
//   out_illegal       unsupported operation
// -----------------------------------------------------------------------------
module exec_unit_pipelined #(
  parameter int XLEN      = 32,
  parameter int AW        = 10,
  parameter int MULDIV_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      in_type,
  input  logic [3:0]      in_alu_op,
  input  logic            in_muldiv,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_op0,
  input  logic [XLEN-1:0] in_op1,
  input  logic [XLEN-1:0] in_imm,
  input  logic [AW-1:0]   in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_branch,
  output logic [AW-1:0]   out_target,
  output logic [XLEN-1:0] out_mem_addr,
  output logic [XLEN-1:0] out_store_data,
  output logic            out_illegal
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;

  logic            out_free, accept, m_req, is_m;

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state_q == IDLE) && out_free;
  assign accept   = in_valid && in_ready;
  assign m_req    = in_muldiv && in_type[0];
  assign is_m     = (MULDIV_EN != 0) && m_req;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] op_b, alu_res;
  logic            alu_bad;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    op_b    = (in_type[1] || in_type[2]) ? in_imm : in_op1;
    alu_res = '0;
    alu_bad = 1'b0;
    case (in_alu_op)
      4'd0:    alu_res = in_op0 + op_b;
      4'd1:    alu_res = in_op0 - op_b;
      4'd2:    alu_res = in_op0 << op_b[SHW-1:0];
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(in_op0) < $signed(op_b)};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, in_op0 < op_b};
      4'd5:    alu_res = in_op0 ^ op_b;
      4'd6:    alu_res = in_op0 >> op_b[SHW-1:0];
      4'd7:    alu_res = $signed(in_op0) >>> op_b[SHW-1:0];
      4'd8:    alu_res = in_op0 | op_b;
      4'd9:    alu_res = in_op0 & op_b;
      4'd10:   alu_res = op_b;
      default: alu_bad = 1'b1;
    endcase
  end

  logic br_taken, br_bad;
  logic br_eq, br_lt, br_ltu;

  assign br_eq  = in_op0 == in_op1;
  assign br_lt  = $signed(in_op0) < $signed(in_op1);
  assign br_ltu = in_op0 < in_op1;

  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (in_funct3)
      3'd0:    br_taken = br_eq;
      3'd1:    br_taken = !br_eq;
      3'd4:    br_taken = br_lt;
      3'd5:    br_taken = !br_lt;
      3'd6:    br_taken = br_ltu;
      3'd7:    br_taken = !br_ltu;
      default: br_bad   = 1'b1;
    endcase
  end

  logic [XLEN-1:0] st_data;
  logic            st_bad;

  always_comb begin
    st_data = '0;
    st_bad  = 1'b0;
    case (in_funct3)
      3'd0: st_data = XLEN'(in_op1[7:0]);
      3'd1: st_data = XLEN'(in_op1[15:0]);
      3'd2: st_data = XLEN'(in_op1[31:0]);
      3'd3: begin
        // Doubleword stores only exist on the 64-bit datapath.
        if (XLEN == 64) st_data = in_op1;
        else            st_bad  = 1'b1;
      end
      default: st_bad = 1'b1;
    endcase
  end

  logic [AW-1:0]   link_pc, target_sum;
  logic [XLEN-1:0] s_result, s_store;
  logic [AW-1:0]   s_target;
  logic            s_branch, s_illegal;

  assign link_pc    = in_pc + AW'(4);
  assign target_sum = in_pc + in_imm[AW-1:0];

  always_comb begin
    s_result  = alu_res;
    s_branch  = 1'b0;
    s_target  = '0;
    s_store   = '0;
    s_illegal = alu_bad;
    if (m_req) begin
      // Only reaches the output register when the M unit is absent.
      s_result  = '0;
      s_illegal = 1'b1;
    end else if (in_type[5]) begin
      s_result  = XLEN'(link_pc);
      s_branch  = 1'b1;
      s_target  = target_sum;
      s_illegal = 1'b0;
    end else begin
      if (in_type[3]) begin
        s_branch  = br_taken && !br_bad;
        s_target  = target_sum;
        s_illegal = alu_bad || br_bad;
      end
      if (in_type[2]) begin
        s_store   = st_data;
        s_illegal = alu_bad || st_bad;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Iterative multiply / divide on operand magnitudes
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] m_hi, m_lo, m_d, m_dividend, m_addr;
  logic [2:0]      m_fn;
  logic            m_neg, m_rem_neg, m_div0;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_signed = in_funct3 inside {3'd1, 3'd2, 3'd4, 3'd6};
  assign b_signed = in_funct3 inside {3'd1, 3'd4, 3'd6};
  assign a_neg    = a_signed && in_op0[XLEN-1];
  assign b_neg    = b_signed && in_op1[XLEN-1];
  assign a_mag    = a_neg ? -in_op0 : in_op0;
  assign b_mag    = b_neg ? -in_op1 : in_op1;

  // Multiply step: {hi,lo} holds partial product and the unconsumed multiplier.
  logic [XLEN:0]   mul_sum;
  // Divide step: lo shifts the dividend out and the quotient in; hi is remainder.
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] it_hi, it_lo;

  always_comb begin
    mul_sum   = {1'b0, m_hi} + (m_lo[0] ? {1'b0, m_d} : '0);
    div_shift = {m_hi, m_lo[XLEN-1]};
    div_ge    = div_shift >= {1'b0, m_d};
    div_diff  = div_shift - {1'b0, m_d};
    if (m_fn[2]) begin
      it_hi = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      it_lo = {m_lo[XLEN-2:0], div_ge};
    end else begin
      it_hi = mul_sum[XLEN:1];
      it_lo = {mul_sum[0], m_lo[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] m_prod;
  logic [XLEN-1:0]   m_quo, m_rem, m_result;

  always_comb begin
    m_prod = m_neg ? -{m_hi, m_lo} : {m_hi, m_lo};
    m_quo  = m_neg ? -m_lo : m_lo;
    m_rem  = m_rem_neg ? -m_hi : m_hi;
    case (m_fn)
      3'd0:       m_result = m_prod[XLEN-1:0];
      3'd4, 3'd5: m_result = m_div0 ? '1 : m_quo;
      3'd6, 3'd7: m_result = m_div0 ? m_dividend : m_rem;
      default:    m_result = m_prod[2*XLEN-1:XLEN];
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_m)              state_d = BUSY;
      BUSY:    if (cnt_q == CW'(XLEN - 1))      state_d = DONE;
      DONE:    if (out_free)                    state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == BUSY) cnt_q <= cnt_q + CW'(1);
      else                 cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi       <= '0;
      m_lo       <= '0;
      m_d        <= '0;
      m_dividend <= '0;
      m_addr     <= '0;
      m_fn       <= '0;
      m_neg      <= 1'b0;
      m_rem_neg  <= 1'b0;
      m_div0     <= 1'b0;
    end else if (accept && is_m) begin
      m_hi       <= '0;
      m_lo       <= a_mag;
      m_d        <= b_mag;
      m_dividend <= in_op0;
      m_addr     <= in_op0 + in_imm;
      m_fn       <= in_funct3;
      m_neg      <= a_neg ^ b_neg;
      m_rem_neg  <= a_neg;
      m_div0     <= in_op1 == '0;
    end else if (state_q == BUSY) begin
      m_hi <= it_hi;
      m_lo <= it_lo;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: loads only on a new result, otherwise holds
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_branch     <= 1'b0;
      out_target     <= '0;
      out_mem_addr   <= '0;
      out_store_data <= '0;
      out_illegal    <= 1'b0;
    end else if (accept && !is_m) begin
      out_valid      <= 1'b1;
      out_result     <= s_result;
      out_branch     <= s_branch;
      out_target     <= s_target;
      out_mem_addr   <= in_op0 + in_imm;
      out_store_data <= s_store;
      out_illegal    <= s_illegal;
    end else if (state_q == DONE && out_free) begin
      out_valid      <= 1'b1;
      out_result     <= m_result;
      out_branch     <= 1'b0;
      out_target     <= '0;
      out_mem_addr   <= m_addr;
      out_store_data <= '0;
      out_illegal    <= 1'b0;
    end else if (out_ready) begin
      out_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_unit_pipelined.sv
// -----------------------------------------------------------------------------
// tb_exec_unit_pipelined
//
// Self-checking bench for exec_unit_pipelined (XLEN=32, AW=10, M unit on).
// Directed cases for the key corner values, then randomized traffic with
// random backpressure checked through a scoreboard fed by a reference model.
// -----------------------------------------------------------------------------
module tb_exec_unit_pipelined;

  localparam int XLEN = 32;
  localparam int AW   = 10;

  typedef struct packed {
    logic [5:0]  typ;
    logic [3:0]  alu_op;
    logic        muldiv;
    logic [2:0]  funct3;
    logic [31:0] op0;
    logic [31:0] op1;
    logic [31:0] imm;
    logic [9:0]  pc;
  } op_t;

  typedef struct packed {
    logic [31:0] result;
    logic        branch;
    logic [9:0]  target;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic        illegal;
  } exp_t;

  logic            clk, rst_n;
  logic            in_valid, in_ready, in_muldiv;
  logic [5:0]      in_type;
  logic [3:0]      in_alu_op;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_op0, in_op1, in_imm;
  logic [AW-1:0]   in_pc;
  logic            out_valid, out_ready, out_branch, out_illegal;
  logic [XLEN-1:0] out_result, out_mem_addr, out_store_data;
  logic [AW-1:0]   out_target;

  exec_unit_pipelined #(.XLEN(XLEN), .AW(AW), .MULDIV_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_alu_op(in_alu_op), .in_muldiv(in_muldiv),
    .in_funct3(in_funct3), .in_op0(in_op0), .in_op1(in_op1),
    .in_imm(in_imm), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_branch(out_branch), .out_target(out_target),
    .out_mem_addr(out_mem_addr), .out_store_data(out_store_data),
    .out_illegal(out_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string pfx, input exp_t e);
    check({pfx, ".result"},     out_result,     e.result);
    check({pfx, ".branch"},     out_branch,     e.branch);
    check({pfx, ".target"},     out_target,     e.target);
    check({pfx, ".mem_addr"},   out_mem_addr,   e.mem_addr);
    check({pfx, ".store_data"}, out_store_data, e.store_data);
    check({pfx, ".illegal"},    out_illegal,    e.illegal);
  endtask

  // Reference model: architectural meaning of each operation.
  function automatic exp_t model_exec(input op_t op);
    exp_t        e;
    logic [31:0] b;
    logic [63:0] p;
    logic [9:0]  link;
    longint      sa, sbv, ua, ub;
    bit          ovf;
    e = '0;
    e.mem_addr = op.op0 + op.imm;
    b = (op.typ[1] || op.typ[2]) ? op.imm : op.op1;
    if (op.typ[0] && op.muldiv) begin
      sa  = longint'($signed(op.op0));
      sbv = longint'($signed(op.op1));
      ua  = longint'({32'd0, op.op0});
      ub  = longint'({32'd0, op.op1});
      ovf = (op.op0 == 32'h8000_0000) && (op.op1 == 32'hFFFF_FFFF);
      case (op.funct3)
        3'd0: begin p = ua * ub;  e.result = p[31:0];  end
        3'd1: begin p = sa * sbv; e.result = p[63:32]; end
        3'd2: begin p = sa * ub;  e.result = p[63:32]; end
        3'd3: begin p = ua * ub;  e.result = p[63:32]; end
        3'd4: begin
          if (op.op1 == 0) e.result = 32'hFFFF_FFFF;
          else if (ovf)    e.result = op.op0;
          else begin p = sa / sbv; e.result = p[31:0]; end
        end
        3'd5: e.result = (op.op1 == 0) ? 32'hFFFF_FFFF : op.op0 / op.op1;
        3'd6: begin
          if (op.op1 == 0) e.result = op.op0;
          else if (ovf)    e.result = 32'd0;
          else begin p = sa % sbv; e.result = p[31:0]; end
        end
        default: e.result = (op.op1 == 0) ? op.op0 : op.op0 % op.op1;
      endcase
    end else if (op.typ[5]) begin
      link     = op.pc + 10'd4;
      e.result = {22'd0, link};
      e.branch = 1'b1;
      e.target = op.pc + op.imm[9:0];
    end else begin
      case (op.alu_op)
        4'd0:  e.result = op.op0 + b;
        4'd1:  e.result = op.op0 - b;
        4'd2:  e.result = op.op0 << (b % 32);
        4'd3:  e.result = (int'(op.op0) < int'(b)) ? 32'd1 : 32'd0;
        4'd4:  e.result = (op.op0 < b) ? 32'd1 : 32'd0;
        4'd5:  e.result = op.op0 ^ b;
        4'd6:  e.result = op.op0 >> (b % 32);
        4'd7:  e.result = 32'(int'(op.op0) >>> (b % 32));
        4'd8:  e.result = op.op0 | b;
        4'd9:  e.result = op.op0 & b;
        4'd10: e.result = b;
        default: e.illegal = 1'b1;
      endcase
      if (op.typ[3]) begin
        e.target = op.pc + op.imm[9:0];
        case (op.funct3)
          3'd0: e.branch = op.op0 == op.op1;
          3'd1: e.branch = op.op0 != op.op1;
          3'd4: e.branch = int'(op.op0) <  int'(op.op1);
          3'd5: e.branch = int'(op.op0) >= int'(op.op1);
          3'd6: e.branch = op.op0 <  op.op1;
          3'd7: e.branch = op.op0 >= op.op1;
          default: e.illegal = 1'b1;
        endcase
      end
      if (op.typ[2]) begin
        case (op.funct3)
          3'd0: e.store_data = {24'd0, op.op1[7:0]};
          3'd1: e.store_data = {16'd0, op.op1[15:0]};
          3'd2: e.store_data = op.op1;
          default: e.illegal = 1'b1;
        endcase
      end
    end
    return e;
  endfunction

  function automatic op_t mk_op(input logic [5:0] typ, input logic [3:0] alu_op,
                                input logic md, input logic [2:0] f3,
                                input logic [31:0] op0, input logic [31:0] op1,
                                input logic [31:0] imm, input logic [9:0] pc);
    op_t o;
    o.typ = typ; o.alu_op = alu_op; o.muldiv = md; o.funct3 = f3;
    o.op0 = op0; o.op1 = op1; o.imm = imm; o.pc = pc;
    return o;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.typ    = 6'b1 << $urandom_range(0, 5);
    o.alu_op = o.typ[5] ? 4'($urandom_range(0, 10)) : 4'($urandom_range(0, 15));
    o.muldiv = ($urandom_range(0, 3) == 0);
    o.funct3 = 3'($urandom);
    o.op0    = pick_val();
    o.op1    = pick_val();
    o.imm    = $urandom_range(0, 1) ? $urandom : 32'($signed(12'($urandom)));
    o.pc     = 10'($urandom);
    return o;
  endfunction

  task automatic drive_op(input op_t op);
    in_type = op.typ; in_alu_op = op.alu_op; in_muldiv = op.muldiv;
    in_funct3 = op.funct3; in_op0 = op.op0; in_op1 = op.op1;
    in_imm = op.imm; in_pc = op.pc;
  endtask

  // One clock of scoreboarded traffic; entered and left at a falling edge.
  task automatic step(input logic v, input op_t op, input logic ordy, output logic acc);
    if (out_valid) begin
      if (sb.size() == 0) check("spurious_valid", out_valid, 1'b0);
      else                check_out("sb", sb[0]);
    end
    in_valid  = v;
    out_ready = ordy;
    drive_op(op);
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
    if (acc) sb.push_back(model_exec(op));
    @(negedge clk);
  endtask

  task automatic drain();
    logic acc;
    op_t  idle_op;
    idle_op = '0;
    for (int i = 0; i < 300 && sb.size() > 0; i++) step(1'b0, idle_op, 1'b1, acc);
    check("drain_empty", sb.size(), 0);
  endtask

  // Single isolated op with the output free: measures edges from accept to valid.
  task automatic run_lat(input string name, input op_t op, input int exp_lat, output exp_t obs);
    int   lat;
    logic rdy_seen;
    exp_t e;
    e = model_exec(op);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    drive_op(op);
    #1 check({name, ".in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({name, ".latency"}, lat, exp_lat);
    if (exp_lat > 0) check({name, ".in_ready_busy"}, rdy_seen, 1'b0);
    check_out(name, e);
    obs.result = out_result;   obs.branch = out_branch;   obs.target = out_target;
    obs.mem_addr = out_mem_addr; obs.store_data = out_store_data; obs.illegal = out_illegal;
    @(negedge clk);
  endtask

  initial begin
    exp_t obs;
    op_t  cur, add_op, sub_op, idle_op;
    logic acc;

    idle_op = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive_op(idle_op);
    repeat (3) @(negedge clk);
    check("reset.out_valid",  out_valid,  1'b0);
    check("reset.out_result", out_result, 32'd0);
    check("reset.out_target", out_target, 10'd0);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("reset.in_ready", in_ready, 1'b1);
    @(negedge clk);

    // ADD via I-type immediate, single-cycle latency
    run_lat("add", mk_op(6'b000010, 4'd0, 1'b0, 3'd0, 32'd5, 32'd0, -32'sd3, 10'd0), 0, obs);
    check("add.const", obs.result, 32'd2);

    // Back-to-back ADD then SUB, one result per cycle
    add_op = mk_op(6'b000010, 4'd0, 1'b0, 3'd0, 32'd5, 32'd0, -32'sd3, 10'd0);
    sub_op = mk_op(6'b000001, 4'd1, 1'b0, 3'd0, 32'd7, 32'd9, 32'd0, 10'd0);
    step(1'b1, add_op, 1'b1, acc);
    check("b2b.add", out_result, 32'd2);
    step(1'b1, sub_op, 1'b1, acc);
    check("b2b.sub", out_result, 32'hFFFF_FFFE);
    drain();

    // Branches
    run_lat("blt", mk_op(6'b001000, 4'd0, 1'b0, 3'd4, 32'hFFFF_FFFF, 32'd1, -32'sd8, 10'h100), 0, obs);
    check("blt.branch", obs.branch, 1'b1);
    check("blt.target", obs.target, 10'h0F8);
    run_lat("bltu", mk_op(6'b001000, 4'd0, 1'b0, 3'd6, 32'hFFFF_FFFF, 32'd1, -32'sd8, 10'h100), 0, obs);
    check("bltu.branch", obs.branch, 1'b0);
    run_lat("jal", mk_op(6'b100000, 4'd0, 1'b0, 3'd0, 32'd0, 32'd0, 32'h40, 10'h120), 0, obs);
    check("jal.link", obs.result, 32'h124);

    // Stores
    run_lat("sb", mk_op(6'b000100, 4'd0, 1'b0, 3'd0, 32'h1000, 32'h1234_5678, 32'd4, 10'd0), 0, obs);
    check("sb.addr", obs.mem_addr, 32'h1004);
    check("sb.data", obs.store_data, 32'h78);
    run_lat("bad_alu", mk_op(6'b000100, 4'd12, 1'b0, 3'd0, 32'h1000, 32'h1234_5678, 32'd4, 10'd0), 0, obs);
    check("bad_alu.illegal", obs.illegal, 1'b1);

    // M ops: XLEN+1 edges from accept to valid
    run_lat("div0", mk_op(6'b000001, 4'd0, 1'b1, 3'd4, 32'd7, 32'd0, 32'd0, 10'd0), XLEN + 1, obs);
    check("div0.const", obs.result, 32'hFFFF_FFFF);
    run_lat("rem_ovf", mk_op(6'b000001, 4'd0, 1'b1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 10'd0), XLEN + 1, obs);
    check("rem_ovf.const", obs.result, 32'd0);
    run_lat("mulh", mk_op(6'b000001, 4'd0, 1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 32'd0, 10'd0), XLEN + 1, obs);
    check("mulh.const", obs.result, 32'hFFFF_FFFF);

    // Backpressure: one result held, a second waiting upstream
    step(1'b1, add_op, 1'b0, acc);
    check("bp.first_accept", acc, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, sub_op, 1'b0, acc);
      check("bp.in_ready_low", acc, 1'b0);
    end
    step(1'b1, sub_op, 1'b1, acc);
    check("bp.second_accept", acc, 1'b1);
    drain();

    // Reset in the middle of a DIVU
    step(1'b1, mk_op(6'b000001, 4'd0, 1'b1, 3'd5, 32'd1000, 32'd7, 32'd0, 10'd0), 1'b1, acc);
    check("rst_div.accept", acc, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, idle_op, 1'b1, acc);
    rst_n = 1'b0;
    #1 check("rst_div.out_valid", out_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    #1 check("rst_div.in_ready", in_ready, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 40; i++) step(1'b0, idle_op, 1'b1, acc);

    // Randomized traffic with random backpressure
    cur = rand_op();
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 3) != 0, cur, $urandom_range(0, 3) != 0, acc);
      if (acc) cur = rand_op();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
